// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared defaults and encodings for the data-memory arbiter
package dm_arbiter_pkg;
    localparam int DEPTH_DEF = 3072;
    localparam int MAX_WAIT_DEF = 4;
    typedef enum logic {NORM, FORCE} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_CPU, SEL_DMA} sel_t;
endpackage

// File: rtl/dm_arbiter_starve_cnt.sv
// starve_cnt: saturating count of consecutive DMA losses
module starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (reset || clr) cnt <= '0;
        else if (inc && cnt != W'(MAX)) cnt <= cnt + 1'b1;
    assign at_limit = cnt == W'(MAX - 1);
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: single-port data-memory arbiter between CPU and DMA with
// anti-starvation forcing; read tags are registered, rvalid is masked while reset is high.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_stall,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        err
);
    state_t state;
    sel_t sel;
    logic blk, rst_q, both, at_limit, issue, oor, w_we;
    logic c_rv_q, d_rv_q, zero_q;
    logic [29:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0] unused_lsb;
    assign unused_lsb = c_addr[1:0] ^ d_addr[1:0];
    // nothing is issued in the reset cycle nor the cycle right after it
    assign blk = reset || rst_q;
    always_comb
        sel = blk ? SEL_NONE
            : state == FORCE ? (d_req ? SEL_DMA : c_req ? SEL_CPU : SEL_NONE)
            : (c_req ? SEL_CPU : d_req ? SEL_DMA : SEL_NONE);
    assign issue = sel != SEL_NONE;
    assign w_addr = sel == SEL_DMA ? d_addr[31:2] : c_addr[31:2];
    assign w_wdata = sel == SEL_DMA ? d_wdata : c_wdata;
    assign w_we = sel == SEL_DMA ? d_we : c_we;
    assign oor = w_addr >= 30'(DEPTH);
    assign mem_en = issue && !oor;
    assign mem_we = mem_en && w_we;
    assign mem_addr = w_addr[11:0];
    assign mem_wdata = w_wdata;
    assign err = issue && oor;
    assign c_stall = c_req && !blk && sel != SEL_CPU;
    assign d_gnt = d_req && sel == SEL_DMA;
    assign both = !blk && state == NORM && c_req && d_req;
    starve_cnt #(.MAX(MAX_WAIT)) u_starve (
        .clk(clk),
        .reset(reset),
        .clr(!both),
        .inc(both),
        .at_limit(at_limit)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state <= NORM;
            rst_q <= 1'b1;
            c_rv_q <= 1'b0;
            d_rv_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state <= (both && at_limit) ? FORCE : NORM;
            rst_q <= 1'b0;
            c_rv_q <= sel == SEL_CPU && !w_we;
            d_rv_q <= sel == SEL_DMA && !w_we;
            zero_q <= oor;
        end
    assign c_rvalid = c_rv_q && !reset;
    assign d_rvalid = d_rv_q && !reset;
    assign c_rdata = (c_rvalid && !zero_q) ? mem_rdata : '0;
    assign d_rdata = (d_rvalid && !zero_q) ? mem_rdata : '0;
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DEPTH, default 3072, data-memory size in 32-bit words.
REQ-002 Parameter MAX_WAIT, default 4, consecutive DMA-loss cycles before DMA is forced.
REQ-003 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 c_req  in  1  CPU M-stage access request (lw/sw).
REQ-006 c_we  in  1  CPU write enable (sw=1, lw=0).
REQ-007 c_addr  in  32  CPU byte address; bits [1:0] ignored.
REQ-008 c_wdata  in  32  CPU store data.
REQ-009 c_stall  out  1  CPU must hold pipeline this cycle.
REQ-010 c_rvalid / c_rdata  out  1 / 32  CPU load response.
REQ-011 d_req, d_we, d_addr[31:0], d_wdata[31:0]  in  DMA request, same semantics as CPU.
REQ-012 d_gnt  out  1  DMA request accepted this cycle.
REQ-013 d_rvalid / d_rdata  out  1 / 32  DMA load response.
REQ-014 mem_en, mem_we  out  1  single-port RAM strobe and write enable.
REQ-015 mem_addr  out  12  word address; mem_wdata  out  32; mem_rdata  in  32, valid one cycle after mem_en.
REQ-016 err  out  1  one-cycle pulse: an accepted access was out of range.

Function
REQ-017 At most one access issued to RAM per cycle; mem_addr = winner addr[13:2].
REQ-018 States: NORM (CPU priority) and FORCE (DMA priority); reset state NORM.
REQ-019 NORM: c_req wins; d_req alone wins; loser's wait_cnt increments, saturating at MAX_WAIT.
REQ-020 NORM -> FORCE when d_req && c_req && wait_cnt == MAX_WAIT-1 at a clock edge.
REQ-021 FORCE: d_req wins, c_stall=1 if c_req; next state NORM, wait_cnt cleared.
REQ-022 FORCE with d_req low (request withdrawn): CPU served, return to NORM, wait_cnt cleared.
REQ-023 wait_cnt cleared whenever DMA wins or d_req is low.
REQ-024 c_stall combinational: c_req && CPU not winner this cycle; CPU holds c_* stable while stalled.
REQ-025 d_gnt combinational: d_req && DMA winner; DMA holds d_* stable until d_gnt.
REQ-026 Read latency: rvalid of winning read port asserts exactly one cycle after issue, rdata = mem_rdata; writes produce no rvalid.
REQ-027 Out of range (word address >= DEPTH): request accepted (no stall / d_gnt=1), mem_en=0, err=1 same cycle; a read returns rvalid=1, rdata=0 next cycle.
REQ-028 Write-then-read of same address on consecutive cycles returns new data (RAM write-first; no bypass in arbiter).
REQ-029 Simultaneous c_req and d_req to same address: CPU order first unless FORCE.

Reset
REQ-030 reset overrides all: state NORM, wait_cnt=0, pending-read tags cleared.
REQ-031 During and one cycle after reset: c_rvalid=d_rvalid=0, mem_en=0, err=0, c_stall=0, d_gnt=0; read issued in the reset cycle's predecessor yields no rvalid.

Structure
REQ-032 Shared package holds DEPTH, MAX_WAIT defaults, state enum {NORM, FORCE}, port-select encoding.
REQ-033 Sub-module starve_cnt (saturating wait counter with clear/inc/at_limit) is instantiated once; rest is flat.
REQ-034 All outputs except c_stall, d_gnt, err, mem_* come from registers.

Verification
REQ-035 CPU only: sw 0x10<=0xDEADBEEF, then lw 0x10 -> c_stall=0 throughout, c_rvalid next cycle with 0xDEADBEEF.
REQ-036 Continuous c_req and d_req, MAX_WAIT=4 -> DMA granted exactly on cycle 5, c_stall=1 that cycle only, pattern repeats every 5 cycles.
REQ-037 d_req dropped in FORCE cycle -> CPU served, c_stall=0, state NORM, wait_cnt=0.
REQ-038 lw at byte addr 0x3000 (word 3072) -> mem_en=0, err=1, c_rvalid next cycle with 0.
REQ-039 DMA read issued, reset asserted next edge -> d_rvalid stays 0, state NORM.
REQ-040 CPU sw and DMA lw same addr same cycle -> DMA read (next cycle) returns CPU-written value.
